mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the processor's single memory port between the instruction-fetch requester and the load/store data requester. Loads and stores have fixed priority over fetch, with a starvation guard that forces a fetch grant after a bounded run of data grants. The block sits between the fetch/LSU logic and the unified memory interface. It keeps one transaction outstanding at a time, latches the winning request, and routes the response back to its owner.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- STARVE_LIM, 4, consecutive data grants with fetch pending before fetch is forced (>=1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid
- if_rdata  out  DATA_W  fetch response data
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid (loads and stores)
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  latched request payload
- mem_gnt  in  1  memory accepted mem_req
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  DATA_W  memory response data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, RESP. Owner register: FETCH or DATA.
- IDLE, winner selection:
  - With d_req=1, DATA wins, unless starve_cnt == STARVE_LIM and if_req=1; then FETCH wins.
  - Otherwise, with if_req=1, FETCH wins.
- In IDLE, if a winner exists:
  - The winner's gnt is driven combinationally high for that cycle.
  - The payload is latched into the mem_* registers. A fetch latches mem_we=0 and mem_be=all ones.
  - The owner is recorded and the state moves to REQ.
- REQ: mem_req=1. On mem_gnt=1, go to RESP. Payload stays stable.
- RESP: mem_req=0. On mem_rvalid=1, the owner's rvalid=1 for that cycle and the state returns to IDLE. rdata passes through combinationally from mem_rdata.
- mem_rvalid outside RESP is ignored and produces no rvalid.
- starve_cnt (width clog2(STARVE_LIM+1)) updates on each grant:
  - Data grant with if_req=1: increment, saturating at STARVE_LIM.
  - Data grant with if_req=0: clear.
  - Fetch grant: clear.
- if_rdata/d_rdata equal mem_rdata at all times. Consumers qualify them with rvalid.
- Reset at any time forces IDLE and clears owner, starve_cnt and all mem_* registers. An in-flight transaction is abandoned, and a late mem_rvalid after reset is ignored.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, busy=0.
- Request sampled in IDLE at cycle N: gnt in cycle N, mem_req high from N+1.
- With mem_gnt at N+1 and mem_rvalid at N+2: response at N+2, next grant no earlier than N+3.
- Minimum 3 cycles per transaction.
- Each extra cycle of mem_gnt or mem_rvalid delay adds one cycle. There is no timeout.
- gnt and rvalid are single-cycle pulses and never asserted for both requesters in the same cycle.
- Requesters must not change the payload while req=1 and gnt=0.

## Test plan
- Fetch only: if_req=1, if_addr=0x100; memory grants immediately and returns 0xDEADBEEF one cycle later -> if_gnt at cycle 0, mem_req cycles 1, mem_addr=0x100, mem_be=0xF, if_rvalid with if_rdata=0xDEADBEEF at cycle 2, d_rvalid never set.
- Simultaneous: if_req=1, d_req=1 store to 0x200, d_wdata=0x12345678, d_be=0x3 -> d_gnt first, mem_we=1, mem_be=0x3; fetch granted the cycle after d_rvalid returns to IDLE.
- Starvation: d_req and if_req held high continuously with STARVE_LIM=4 -> data granted 4 times, 5th grant is if_gnt, then the count restarts from 0.
- Stalled memory: mem_gnt low 3 cycles, then mem_rvalid delayed 2 cycles -> mem_req and payload stable throughout, busy=1, single rvalid pulse, no new gnt while busy.
- Reset mid-transaction: assert rst while in RESP -> all outputs reset values immediately; mem_rvalid pulse after rst release produces no rvalid.
- Spurious response: mem_rvalid=1 in IDLE with no requests -> no rvalid, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Data has priority; a starvation counter forces a fetch grant after a bounded data run.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   typedef enum logic {FETCH, DATA} owner_t;

   state_t           state, state_nxt;
   owner_t           owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             starved, pick_f, pick_d;

   // Grants are gated by rst so nothing leaks out while reset is held.
   assign starved = (starve_cnt == LIM) && if_req;
   assign pick_d  = !rst && (state == IDLE) && d_req && !starved;
   assign pick_f  = !rst && (state == IDLE) && if_req && !pick_d;

   always_comb begin
      state_nxt = state;
      if_gnt    = pick_f;
      d_gnt     = pick_d;
      mem_req   = (state == REQ);
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: if (pick_f || pick_d) state_nxt = REQ;
         REQ:  if (mem_gnt) state_nxt = RESP;
         RESP: if (mem_rvalid) begin
            state_nxt = IDLE;
            if_rvalid = (owner == FETCH);
            d_rvalid  = (owner == DATA);
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign if_rdata = mem_rdata;
   assign d_rdata  = mem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= FETCH;
         starve_cnt <= '0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state <= state_nxt;
         if (pick_f) begin
            owner      <= FETCH;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_be     <= '1;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
         end else if (pick_d) begin
            owner     <= DATA;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Count only data wins that actually held off a waiting fetch.
            if (!if_req)            starve_cnt <= '0;
            else if (starve_cnt != LIM) starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, inline checks.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [3:0]  d_be, mem_be;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   int checks = 0, errors = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after a rising edge; outputs are sampled 1ns after that.
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick(); #1;
      checks++; if ({mem_req, mem_we, mem_be, busy} !== 7'b0) begin errors++; $display("FAIL reset_ctl got req=%b we=%b be=%h busy=%b exp all 0", mem_req, mem_we, mem_be, busy); end
      checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_payload got addr=%h wdata=%h exp 0", mem_addr, mem_wdata); end
      checks++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== 4'b0) begin errors++; $display("FAIL reset_hs got %b exp 0000", {if_gnt, d_gnt, if_rvalid, d_rvalid}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch_only();
      if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1; #1;
      checks++; if ({if_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt got %b exp 10", {if_gnt, d_gnt}); end
      tick(); if_req = 1'b0; #1;
      checks++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin errors++; $display("FAIL fetch_req got req=%b we=%b be=%h addr=%h exp 1 0 f 100", mem_req, mem_we, mem_be, mem_addr); end
      tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
      checks++; if ({if_rvalid, d_rvalid, mem_req} !== 3'b100) begin errors++; $display("FAIL fetch_rvalid got %b exp 100", {if_rvalid, d_rvalid, mem_req}); end
      checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata got %h exp deadbeef", if_rdata); end
      tick(); mem_rvalid = 1'b0; #1;
      checks++; if ({busy, if_rvalid, d_rvalid} !== 3'b000) begin errors++; $display("FAIL fetch_done got %b exp 000", {busy, if_rvalid, d_rvalid}); end
   endtask

   task automatic test_simultaneous();
      if_req = 1'b1; if_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'h3; #1;
      checks++; if ({if_gnt, d_gnt} !== 2'b01) begin errors++; $display("FAIL sim_gnt got %b exp 01", {if_gnt, d_gnt}); end
      tick(); d_req = 1'b0; mem_gnt = 1'b1; #1;
      checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h200, 32'h12345678}) begin errors++; $display("FAIL sim_store got req=%b we=%b be=%h addr=%h wdata=%h", mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
      checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL sim_busy_gnt got %b exp 0", if_gnt); end
      tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
      checks++; if ({d_rvalid, if_rvalid, if_gnt} !== 3'b100) begin errors++; $display("FAIL sim_d_rvalid got %b exp 100", {d_rvalid, if_rvalid, if_gnt}); end
      tick(); mem_rvalid = 1'b0; #1;
      checks++; if ({if_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL sim_fetch_next got %b exp 10", {if_gnt, d_gnt}); end
      tick(); if_req = 1'b0; mem_gnt = 1'b1; #1;
      checks++; if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, 32'h300}) begin errors++; $display("FAIL sim_fetch_payload got we=%b be=%h addr=%h", mem_we, mem_be, mem_addr); end
      tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
      checks++; if ({if_rvalid, d_rvalid} !== 2'b10) begin errors++; $display("FAIL sim_fetch_rvalid got %b exp 10", {if_rvalid, d_rvalid}); end
      tick(); mem_rvalid = 1'b0; #1;
   endtask

   // Both requesters held high: grants D,D,D,D,F,D. mem_rvalid stays high, so it
   // is also present in IDLE and REQ where it must be ignored.
   task automatic test_starvation();
      logic [5:0] exp_fetch;
      exp_fetch = 6'b010000;
      if_req = 1'b1; if_addr = 32'h400;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_be = 4'hF;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D; #1;
      for (int k = 0; k < 6; k++) begin
         checks++; if ({if_gnt, d_gnt} !== {exp_fetch[k], ~exp_fetch[k]}) begin errors++; $display("FAIL starve_gnt%0d got %b exp %b", k, {if_gnt, d_gnt}, {exp_fetch[k], ~exp_fetch[k]}); end
         tick(); #1;
         checks++; if ({if_rvalid, d_rvalid, mem_req} !== 3'b001) begin errors++; $display("FAIL starve_req%0d got %b exp 001", k, {if_rvalid, d_rvalid, mem_req}); end
         tick(); #1;
         checks++; if ({if_rvalid, d_rvalid} !== {exp_fetch[k], ~exp_fetch[k]}) begin errors++; $display("FAIL starve_rvalid%0d got %b exp %b", k, {if_rvalid, d_rvalid}, {exp_fetch[k], ~exp_fetch[k]}); end
         tick(); #1;
      end
      if_req = 1'b0; d_req = 1'b0; #1;
      checks++; if ({busy, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 5'b00000) begin errors++; $display("FAIL starve_spurious got %b exp 00000", {busy, if_gnt, d_gnt, if_rvalid, d_rvalid}); end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      tick();
   endtask

   task automatic test_stalled();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h440; d_be = 4'hF; #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL stall_gnt got %b exp 1", d_gnt); end
      tick(); d_req = 1'b0; if_req = 1'b1; if_addr = 32'h500;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if ({mem_req, busy, if_gnt, d_gnt, mem_addr} !== {4'b1100, 32'h440}) begin errors++; $display("FAIL stall_req%0d got req=%b busy=%b gnt=%b%b addr=%h", k, mem_req, busy, if_gnt, d_gnt, mem_addr); end
         tick();
      end
      mem_gnt = 1'b1; #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stall_req_gnt got %b exp 1", mem_req); end
      tick(); mem_gnt = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if ({mem_req, busy, if_gnt, d_rvalid, mem_addr} !== {4'b0100, 32'h440}) begin errors++; $display("FAIL stall_resp%0d got req=%b busy=%b gnt=%b rv=%b addr=%h", k, mem_req, busy, if_gnt, d_rvalid, mem_addr); end
         tick();
      end
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
      checks++; if ({d_rvalid, if_rvalid, d_rdata} !== {2'b10, 32'hCAFEF00D}) begin errors++; $display("FAIL stall_rvalid got rv=%b%b rdata=%h exp 10 cafef00d", d_rvalid, if_rvalid, d_rdata); end
      tick(); mem_rvalid = 1'b0; #1;
      checks++; if ({d_rvalid, if_gnt} !== 2'b01) begin errors++; $display("FAIL stall_after got rv=%b gnt=%b exp 0 1", d_rvalid, if_gnt); end
      tick(); if_req = 1'b0;
   endtask

   // Entered with a fetch latched and the arbiter in REQ.
   task automatic test_reset_mid();
      mem_gnt = 1'b1;
      tick(); mem_gnt = 1'b0; #1;
      checks++; if ({busy, mem_req} !== 2'b10) begin errors++; $display("FAIL mid_in_resp got %b exp 10", {busy, mem_req}); end
      rst = 1'b1; #1;
      checks++; if ({busy, mem_req, mem_we, mem_be, mem_addr} !== 39'h0) begin errors++; $display("FAIL mid_reset got busy=%b req=%b we=%b be=%h addr=%h", busy, mem_req, mem_we, mem_be, mem_addr); end
      tick(); rst = 1'b0; mem_rvalid = 1'b1; #1;
      checks++; if ({if_rvalid, d_rvalid, busy} !== 3'b000) begin errors++; $display("FAIL mid_late_rvalid got %b exp 000", {if_rvalid, d_rvalid, busy}); end
      tick(); mem_rvalid = 1'b0;
   endtask

   task automatic test_spurious();
      mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if ({if_rvalid, d_rvalid, busy, mem_req} !== 4'b0000) begin errors++; $display("FAIL spurious%0d got %b exp 0000", k, {if_rvalid, d_rvalid, busy, mem_req}); end
         tick();
      end
      mem_rvalid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0;
      d_addr = '0; d_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      test_reset();
      test_fetch_only();
      test_simultaneous();
      test_starvation();
      test_stalled();
      test_reset_mid();
      test_spurious();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
